// File: rtl/shift_rotate_seq.sv
// shift_rotate_seq: serial WIDTH-bit shift/rotate unit with valid/ready handshakes
module shift_rotate_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_dir,
    input  logic [1:0]         in_mode,
    input  logic               in_fill,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_carry,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_n;
    logic [SHAMT_W-1:0] cnt;
    logic               dir, fill;
    logic [1:0]         mode;
    logic [WIDTH-1:0]   step;
    logic               step_carry, lfill, rfill, accept;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign accept    = in_valid && in_ready;

    // one-bit step of the working register; arithmetic left forces a zero fill
    always_comb begin
        lfill      = mode == 2'b01 ? out_data[WIDTH-1] : (mode == 2'b10 ? 1'b0 : fill);
        rfill      = mode == 2'b01 ? out_data[0] : (mode == 2'b10 ? out_data[WIDTH-1] : fill);
        step       = dir ? {rfill, out_data[WIDTH-1:1]} : {out_data[WIDTH-2:0], lfill};
        step_carry = dir ? out_data[0] : out_data[WIDTH-1];
    end

    // next state: zero amount skips straight to DONE, last step leaves SHIFT
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? (in_shamt == '0 ? DONE : SHIFT) : IDLE;
            SHIFT:   state_n = cnt == SHAMT_W'(1) ? DONE : SHIFT;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // state, operand latch and serial datapath; reset discards any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_data  <= '0;
            out_carry <= 1'b0;
            dir       <= 1'b0;
            mode      <= 2'b00;
            fill      <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                out_data  <= in_data;
                out_carry <= 1'b0;
                cnt       <= in_shamt;
                dir       <= in_dir;
                mode      <= in_mode;
                fill      <= in_fill;
            end else if (state == SHIFT) begin
                out_data  <= step;
                out_carry <= step_carry;
                cnt       <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: doc/shift_rotate_seq.md
# shift_rotate_seq

Parametrised, sequential shift/rotate unit: generalises the fixed 8-bit switch shifter to WIDTH bits, with shift amounts beyond WIDTH, an arithmetic-right mode and a carry-out flag. It computes one bit position per clock, so area stays small at any WIDTH. Requests and results pass over valid/ready handshakes, so the unit can sit between a switch/button front end and the LED driver, or inside a datapath.

## Interface
- WIDTH, 8, data width in bits; ≥ 2.
- SHAMT_W, $clog2(WIDTH)+1, width of the shift-amount field; the maximum amount is 2^SHAMT_W − 1.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift/rotate amount k.
- in_dir  in  1  0 = left, 1 = right.
- in_mode  in  2  00 = logical shift with fill, 01 = rotate, 10 = arithmetic, 11 = reserved (behaves as 00).
- in_fill  in  1  fill bit for logical shift.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result.
- out_carry  out  1  last bit shifted or rotated out; 0 when k = 0.
- busy  out  1  high in SHIFT or DONE.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready = 1. Accept when in_valid & in_ready. On accept, latch in_data, in_dir, in_mode, in_fill; load cnt = in_shamt; clear carry.
  - k = 0: go to DONE.
  - k > 0: go to SHIFT.
- SHIFT: each cycle performs exactly one 1-bit step, sets carry to the bit leaving the register, and decrements cnt. The step that takes cnt from 1 to 0 moves to DONE.
- Step rules:
  - Logical left: {d[W-2:0], fill}, carry = d[W-1].
  - Logical right: {fill, d[W-1:1]}, carry = d[0].
  - Rotate left: {d[W-2:0], d[W-1]}, carry = d[W-1].
  - Rotate right: {d[0], d[W-1:1]}, carry = d[0].
  - Arithmetic right: {d[W-1], d[W-1:1]}, carry = d[0].
  - Arithmetic left: identical to logical left with fill forced to 0.
- Amounts k ≥ WIDTH:
  - Logical: result is all fill bits.
  - Rotate: result equals rotation by k mod WIDTH; carry follows the serial definition.
- DONE: out_valid = 1. out_data and out_carry are held stable until out_valid & out_ready, then the unit returns to IDLE. in_ready = 0 in DONE, so no new request is accepted in the handover cycle.
- in_* signals are ignored outside the accept cycle. Changing in_fill mid-operation has no effect.
- Reset, including mid-SHIFT or mid-DONE, discards the operation with no partial result.
  - Register values: state = IDLE, out_valid = 0, out_data = 0, out_carry = 0, cnt = 0.
  - in_ready = 0 while rst is high, and 1 in the first cycle after reset releases.

## Timing
- Accept in cycle N with amount k: out_valid is first high in cycle N+k+1, so latency is k+1 cycles.
- Worst-case latency is 2^SHAMT_W cycles.
- With out_ready held high, throughput is one result per k+2 cycles: result cycle, then IDLE accept cycle.
- out_data and out_carry are registered outputs. in_ready, out_valid and busy decode from the state register only, with no combinational path from in_valid or out_ready.
- out_data is not guaranteed meaningful while out_valid = 0.

## Test plan
- Logical left, WIDTH=8, data 8'b1011_0010, k=1, fill=1 → out_data 8'b0110_0101, carry 1, out_valid in cycle N+2.
- Rotate right, data 8'b1011_0010, k=3 → out_data 8'b0101_0110, carry 0, out_valid in cycle N+4. The same input rotated left by 3 → 8'b1001_0101, carry 1.
- Arithmetic right, data 8'b1000_0100, k=2 → 8'b1110_0001, carry 0.
- k=0 with any mode and data 8'hA5 → out_data 8'hA5, carry 0, out_valid in cycle N+1.
- Large amount, SHAMT_W=4:
  - Logical left, data 8'hFF, k=9, fill 0 → 8'h00, carry 0, latency 10.
  - Rotate left, data 8'h81, k=9 → 8'h03, carry 1.
- Handshake and reset:
  - Hold out_ready low 5 cycles in DONE → out_data/out_carry stable, in_ready 0, request ignored; raise out_ready → IDLE next cycle.
  - Assert rst during SHIFT → next cycle out_valid 0, out_data 0, busy 0; after release in_ready = 1 and a fresh request completes correctly.
